// File: rtl/dmem_arbiter_if.sv
// Bus bundle for dmem_arbiter: CPU requester, external loader, memory command
// and grant-owner signals. slave = arbiter view, master = requesters/memory view.
interface dmem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ack;

  logic              ext_req;
  logic              ext_we;
  logic [ADDR_W-1:0] ext_addr;
  logic [DATA_W-1:0] ext_wdata;
  logic [DATA_W-1:0] ext_rdata;
  logic              ext_ack;
  logic              ext_excl;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic [1:0]        owner;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack,
    input  ext_req, ext_we, ext_addr, ext_wdata, ext_excl,
    output ext_rdata, ext_ack,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output owner
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack,
    output ext_req, ext_we, ext_addr, ext_wdata, ext_excl,
    input  ext_rdata, ext_ack,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  owner
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester (CPU / external loader) round-robin arbiter in front of a
// single-port synchronous memory. One access per three cycles:
// IDLE (arbitrate, capture) -> ISSUE (mem_en) -> RESP (ack, read data).
module dmem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input logic           clk,
  input logic           reset,
  dmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_CPU  = 2'b01,
    OWN_EXT  = 2'b10
  } owner_t;

  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  logic              last_ext_q, last_ext_d;
  logic              cmd_we_q, cmd_we_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic [DATA_W-1:0] cmd_wdata_q, cmd_wdata_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              ext_ack_q, ext_ack_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] ext_rdata_q, ext_rdata_d;
  logic              cpu_elig, ext_elig, pick_cpu;

  // Next-state: arbitration in IDLE, strobe in ISSUE, ack and read capture in RESP.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_ext_d  = last_ext_q;
    cmd_we_d    = cmd_we_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    cpu_ack_d   = 1'b0;
    ext_ack_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    ext_rdata_d = ext_rdata_q;
    cpu_elig    = bus.cpu_req & ~bus.ext_excl;
    ext_elig    = bus.ext_req;
    // On a tie the CPU wins only if the loader had the previous grant.
    pick_cpu    = cpu_elig & (~ext_elig | last_ext_q);

    unique case (state_q)
      IDLE: begin
        owner_d = OWN_NONE;
        if (cpu_elig | ext_elig) begin
          state_d  = ISSUE;
          mem_en_d = 1'b1;
          if (pick_cpu) begin
            owner_d     = OWN_CPU;
            last_ext_d  = 1'b0;
            cmd_we_d    = bus.cpu_we;
            cmd_addr_d  = bus.cpu_addr;
            cmd_wdata_d = bus.cpu_wdata;
            mem_we_d    = bus.cpu_we;
          end else begin
            owner_d     = OWN_EXT;
            last_ext_d  = 1'b1;
            cmd_we_d    = bus.ext_we;
            cmd_addr_d  = bus.ext_addr;
            cmd_wdata_d = bus.ext_wdata;
            mem_we_d    = bus.ext_we;
          end
        end
      end
      ISSUE: begin
        state_d   = RESP;
        cpu_ack_d = (owner_q == OWN_CPU);
        ext_ack_d = (owner_q == OWN_EXT);
      end
      RESP: begin
        state_d = IDLE;
        owner_d = OWN_NONE;
        if (!cmd_we_q) begin
          if (owner_q == OWN_CPU) cpu_rdata_d = bus.mem_rdata;
          if (owner_q == OWN_EXT) ext_rdata_d = bus.mem_rdata;
        end
      end
      default: begin
        state_d = IDLE;
        owner_d = OWN_NONE;
      end
    endcase
  end

  // State and registered outputs; synchronous reset aborts any access in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= OWN_NONE;
      last_ext_q  <= 1'b1;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      cpu_ack_q   <= 1'b0;
      ext_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      ext_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_ext_q  <= last_ext_d;
      cmd_we_q    <= cmd_we_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      cpu_ack_q   <= cpu_ack_d;
      ext_ack_q   <= ext_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      ext_rdata_q <= ext_rdata_d;
    end
  end

  // Memory data only arrives in the RESP cycle, so a read ack forwards it
  // directly; the holding register takes over from the following cycle.
  assign bus.cpu_rdata = (cpu_ack_q && !cmd_we_q) ? bus.mem_rdata : cpu_rdata_q;
  assign bus.ext_rdata = (ext_ack_q && !cmd_we_q) ? bus.mem_rdata : ext_rdata_q;
  assign bus.cpu_ack   = cpu_ack_q;
  assign bus.ext_ack   = ext_ack_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = cmd_addr_q;
  assign bus.mem_wdata = cmd_wdata_q;
  assign bus.owner     = owner_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a transaction-level model predicts every
// grant, memory command, ack and read value; a negedge monitor compares.
module tb_dmem_arbiter;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int CPU = 1;
  localparam int EXT = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    int            port;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    int            at;
    int            ep;
  } txn_t;
  typedef struct {
    string       nm;
    logic [63:0] act;
    logic [63:0] exp;
  } dchk_t;
  typedef struct {
    int port;
    int at;
  } ackrec_t;

  txn_t    cmd_q[$];
  txn_t    ack_q[$];
  dchk_t   dq[$];
  ackrec_t ack_log[$];

  int n_checks = 0;
  int n_fail = 0;

  function automatic logic [DW-1:0] init_word(input logic [3:0] i);
    if (i == 4'd0) return 32'hDEAD_BEEF;
    if (i == 4'd5) return 32'h0000_0055;
    return 32'hA000_0000 | {28'h0, i};
  endfunction

  // Memory: 16 words aliased on addr[3:0]; read data appears the cycle after
  // the strobe, junk otherwise.
  logic [DW-1:0] mem_arr [16];
  logic [15:0]   mem_wr = '0;
  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_we) begin
      mem_arr[bus.mem_addr[3:0]] <= bus.mem_wdata;
      mem_wr[bus.mem_addr[3:0]]  <= 1'b1;
    end
    if (bus.mem_en && !bus.mem_we)
      bus.mem_rdata <= mem_wr[bus.mem_addr[3:0]] ? mem_arr[bus.mem_addr[3:0]]
                                                 : init_word(bus.mem_addr[3:0]);
    else
      bus.mem_rdata <= $urandom();
  end

  // Reference model: one access at a time, each occupying three cycles from
  // the grant; round-robin on ties; reset discards everything in flight.
  int            edge_cnt = 0;
  int            epoch = 0;
  int            rst_edge = -1;
  int            next_free = 0;
  int            owner_exp = 0;
  int            owner_end = 0;
  bit            last_ext = 1'b1;
  logic [DW-1:0] sh_mem [16];
  logic [15:0]   sh_wr = '0;
  always @(posedge clk) begin
    bit         ce, ee;
    int         pick;
    txn_t       t;
    logic [3:0] ix;
    edge_cnt++;
    if (reset) begin
      epoch++;
      rst_edge  = edge_cnt;
      next_free = edge_cnt + 1;
      last_ext  = 1'b1;
      owner_exp = 0;
    end else begin
      if (edge_cnt >= owner_end) owner_exp = 0;
      ce = bus.cpu_req && !bus.ext_excl;
      ee = bus.ext_req;
      if (edge_cnt >= next_free && (ce || ee)) begin
        pick     = (ce && ee) ? (last_ext ? CPU : EXT) : (ce ? CPU : EXT);
        last_ext = (pick == EXT);
        t.port   = pick;
        t.we     = (pick == CPU) ? bus.cpu_we : bus.ext_we;
        t.addr   = (pick == CPU) ? bus.cpu_addr : bus.ext_addr;
        t.wdata  = (pick == CPU) ? bus.cpu_wdata : bus.ext_wdata;
        ix       = t.addr[3:0];
        if (t.we) begin
          sh_mem[ix] = t.wdata;
          sh_wr[ix]  = 1'b1;
          t.rdata    = '0;
        end else begin
          t.rdata = sh_wr[ix] ? sh_mem[ix] : init_word(ix);
        end
        t.ep = epoch;
        t.at = edge_cnt;
        cmd_q.push_back(t);
        t.at = edge_cnt + 1;
        ack_q.push_back(t);
        owner_exp = pick;
        owner_end = edge_cnt + 2;
        next_free = edge_cnt + 3;
      end
    end
  end

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endfunction

  // Monitor: compares DUT outputs against model predictions every cycle.
  int            seen_epoch = 0;
  logic [DW-1:0] held_cpu = '0;
  logic [DW-1:0] held_ext = '0;
  int            cpu_ack_cnt = 0;
  int            ext_ack_cnt = 0;
  always @(negedge clk) begin
    txn_t    t;
    bit      exp_mem, exp_c, exp_e;
    dchk_t   d;
    ackrec_t r;
    if (epoch != seen_epoch) begin
      seen_epoch = epoch;
      held_cpu   = '0;
      held_ext   = '0;
    end
    while (cmd_q.size() > 0 && cmd_q[0].ep != epoch) void'(cmd_q.pop_front());
    while (ack_q.size() > 0 && ack_q[0].ep != epoch) void'(ack_q.pop_front());
    if (rst_edge == edge_cnt) begin
      chk("rst_mem_addr", 64'(bus.mem_addr), 64'(0));
      chk("rst_mem_wdata", 64'(bus.mem_wdata), 64'(0));
    end
    exp_mem = cmd_q.size() > 0 && cmd_q[0].at == edge_cnt;
    chk("mem_en", 64'(bus.mem_en), 64'(exp_mem));
    if (exp_mem) begin
      t = cmd_q.pop_front();
      chk("mem_we", 64'(bus.mem_we), 64'(t.we));
      chk("mem_addr", 64'(bus.mem_addr), 64'(t.addr));
      chk("mem_wdata", 64'(bus.mem_wdata), 64'(t.wdata));
    end else begin
      chk("mem_we_outside_issue", 64'(bus.mem_we), 64'(0));
    end
    exp_c = 1'b0;
    exp_e = 1'b0;
    if (ack_q.size() > 0 && ack_q[0].at == edge_cnt) begin
      t = ack_q.pop_front();
      if (t.port == CPU) begin
        exp_c = 1'b1;
        if (!t.we) held_cpu = t.rdata;
      end else begin
        exp_e = 1'b1;
        if (!t.we) held_ext = t.rdata;
      end
    end
    chk("cpu_ack", 64'(bus.cpu_ack), 64'(exp_c));
    chk("ext_ack", 64'(bus.ext_ack), 64'(exp_e));
    chk("cpu_rdata", 64'(bus.cpu_rdata), 64'(held_cpu));
    chk("ext_rdata", 64'(bus.ext_rdata), 64'(held_ext));
    chk("owner", 64'(bus.owner), 64'(owner_exp));
    if (bus.cpu_ack) begin
      cpu_ack_cnt++;
      r.port = CPU;
      r.at   = edge_cnt;
      ack_log.push_back(r);
    end
    if (bus.ext_ack) begin
      ext_ack_cnt++;
      r.port = EXT;
      r.at   = edge_cnt;
      ack_log.push_back(r);
    end
    while (dq.size() > 0) begin
      d = dq.pop_front();
      chk(d.nm, d.act, d.exp);
    end
  end

  task automatic expect_d(input string nm, input logic [63:0] act, input logic [63:0] exp);
    dchk_t d;
    d.nm  = nm;
    d.act = act;
    d.exp = exp;
    dq.push_back(d);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input int port, input string nm);
    int n;
    n = 0;
    while (!((port == CPU) ? bus.cpu_ack : bus.ext_ack) && n < 12) begin
      step();
      n++;
    end
    if (!((port == CPU) ? bus.cpu_ack : bus.ext_ack)) expect_d({nm, "_ack_timeout"}, 64'(0), 64'(1));
  endtask

  task automatic wait_mem_en(input string nm);
    int n;
    n = 0;
    while (!bus.mem_en && n < 12) begin
      step();
      n++;
    end
    if (!bus.mem_en) expect_d({nm, "_mem_en_timeout"}, 64'(0), 64'(1));
  endtask

  initial begin
    int  start, c0, e0;
    bit  cpu_pend, ext_pend;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.ext_req = 1'b0; bus.ext_we = 1'b0; bus.ext_addr = '0; bus.ext_wdata = '0;
    bus.ext_excl = 1'b0;
    repeat (3) step();

    // Single CPU read right after reset release.
    reset = 1'b0;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h10;
    step();
    expect_d("single_read_mem_en", 64'(bus.mem_en), 64'(1));
    expect_d("single_read_mem_addr", 64'(bus.mem_addr), 64'h10);
    expect_d("single_read_owner", 64'(bus.owner), 64'(1));
    step();
    expect_d("single_read_ack", 64'(bus.cpu_ack), 64'(1));
    expect_d("single_read_rdata", 64'(bus.cpu_rdata), 64'hDEAD_BEEF);
    bus.cpu_req = 1'b0;
    step();
    expect_d("single_read_owner_idle", 64'(bus.owner), 64'(0));
    expect_d("single_read_rdata_hold", 64'(bus.cpu_rdata), 64'hDEAD_BEEF);

    // Continuous tie after reset: CPU, EXT, CPU, EXT, three cycles apart.
    reset = 1'b1;
    step();
    reset = 1'b0;
    start = ack_log.size();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h31;
    bus.ext_req = 1'b1; bus.ext_we = 1'b0; bus.ext_addr = 32'h42;
    repeat (12) step();
    bus.cpu_req = 1'b0;
    bus.ext_req = 1'b0;
    repeat (3) step();
    expect_d("tie_ack_count", 64'(ack_log.size() - start), 64'(4));
    if (ack_log.size() - start >= 4) begin
      for (int i = 0; i < 4; i++)
        expect_d($sformatf("tie_order_%0d", i), 64'(ack_log[start + i].port),
                 64'((i % 2 == 0) ? CPU : EXT));
      for (int i = 0; i < 3; i++)
        expect_d($sformatf("tie_spacing_%0d", i),
                 64'(ack_log[start + i + 1].at - ack_log[start + i].at), 64'(3));
    end

    // Exclusive load: four loader writes, CPU starved until exclusivity drops.
    c0 = cpu_ack_cnt;
    e0 = ext_ack_cnt;
    bus.ext_excl = 1'b1;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h7;
    for (int i = 0; i < 4; i++) begin
      bus.ext_req = 1'b1; bus.ext_we = 1'b1;
      bus.ext_addr = 32'(i); bus.ext_wdata = 32'h11 + 32'(i);
      step();
      wait_ack(EXT, "excl_load");
    end
    bus.ext_req = 1'b0;
    bus.ext_excl = 1'b0;
    step();
    step();
    expect_d("excl_cpu_grant_mem_en", 64'(bus.mem_en), 64'(1));
    expect_d("excl_cpu_grant_owner", 64'(bus.owner), 64'(1));
    expect_d("excl_cpu_ack_count", 64'(cpu_ack_cnt - c0), 64'(0));
    expect_d("excl_ext_ack_count", 64'(ext_ack_cnt - e0), 64'(4));
    wait_ack(CPU, "excl_cpu");
    bus.cpu_req = 1'b0;
    repeat (2) step();

    // Loader read then write to the same word: rdata keeps the read value.
    bus.ext_req = 1'b1; bus.ext_we = 1'b0; bus.ext_addr = 32'h25;
    wait_ack(EXT, "hold_read");
    expect_d("hold_read_rdata", 64'(bus.ext_rdata), 64'h55);
    bus.ext_we = 1'b1; bus.ext_wdata = 32'hAA;
    step();
    wait_mem_en("hold_write");
    expect_d("hold_write_mem_we", 64'(bus.mem_we), 64'(1));
    expect_d("hold_write_wdata", 64'(bus.mem_wdata), 64'hAA);
    step();
    expect_d("hold_write_ack", 64'(bus.ext_ack), 64'(1));
    expect_d("hold_write_rdata", 64'(bus.ext_rdata), 64'h55);
    bus.ext_req = 1'b0;
    step();
    expect_d("hold_after_write_rdata", 64'(bus.ext_rdata), 64'h55);
    expect_d("hold_after_write_mem_we", 64'(bus.mem_we), 64'(0));
    step();

    // CPU drops req and exclusivity rises mid-access: access still completes.
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h3;
    wait_mem_en("no_abort");
    bus.cpu_req = 1'b0;
    bus.ext_excl = 1'b1;
    step();
    expect_d("no_abort_ack", 64'(bus.cpu_ack), 64'(1));
    expect_d("no_abort_rdata", 64'(bus.cpu_rdata), 64'h14);
    bus.ext_excl = 1'b0;
    repeat (2) step();

    // Reset in the ISSUE cycle of a CPU read.
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h10;
    wait_mem_en("mid_reset");
    reset = 1'b1;
    step();
    expect_d("mid_reset_cpu_ack", 64'(bus.cpu_ack), 64'(0));
    expect_d("mid_reset_mem_en", 64'(bus.mem_en), 64'(0));
    expect_d("mid_reset_owner", 64'(bus.owner), 64'(0));
    expect_d("mid_reset_cpu_rdata", 64'(bus.cpu_rdata), 64'(0));
    expect_d("mid_reset_ext_rdata", 64'(bus.ext_rdata), 64'(0));
    reset = 1'b0;
    bus.ext_req = 1'b1; bus.ext_we = 1'b0; bus.ext_addr = 32'h9;
    step();
    expect_d("post_reset_tie_owner", 64'(bus.owner), 64'(1));
    expect_d("post_reset_tie_addr", 64'(bus.mem_addr), 64'h10);
    bus.cpu_req = 1'b0;
    wait_ack(CPU, "post_reset_cpu");
    step();
    wait_ack(EXT, "post_reset_ext");
    bus.ext_req = 1'b0;
    repeat (3) step();

    // Randomized traffic with exclusivity toggling and occasional resets.
    cpu_pend = 1'b0;
    ext_pend = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (bus.cpu_ack) begin cpu_pend = 1'b0; bus.cpu_req = 1'b0; end
      if (bus.ext_ack) begin ext_pend = 1'b0; bus.ext_req = 1'b0; end
      if (!cpu_pend && $urandom_range(2, 0) == 0) begin
        cpu_pend = 1'b1;
        bus.cpu_req = 1'b1;
        bus.cpu_we = 1'($urandom_range(1, 0));
        bus.cpu_addr = $urandom();
        bus.cpu_wdata = $urandom();
      end
      if (!ext_pend && $urandom_range(2, 0) == 0) begin
        ext_pend = 1'b1;
        bus.ext_req = 1'b1;
        bus.ext_we = 1'($urandom_range(1, 0));
        bus.ext_addr = $urandom();
        bus.ext_wdata = $urandom();
      end
      if ($urandom_range(7, 0) == 0) bus.ext_excl = ~bus.ext_excl;
      reset = ($urandom_range(299, 0) == 0);
      step();
    end
    reset = 1'b0;
    bus.cpu_req = 1'b0;
    bus.ext_req = 1'b0;
    bus.ext_excl = 1'b0;
    repeat (6) step();
    expect_d("drain_cmd_queue", 64'(cmd_q.size()), 64'(0));
    expect_d("drain_ack_queue", 64'(ack_q.size()), 64'(0));
    repeat (2) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 32, address width of both requester ports and the memory port.
REQ-002 Parameter: DATA_W, default 32, data width of all read and write data buses.
REQ-003 Port: clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 Port: reset  in  1  synchronous, active-high reset.
REQ-005 Port: cpu_req  in  1  CPU access request; held high until cpu_ack.
REQ-006 Port: cpu_we  in  1  CPU write enable (1 = write, 0 = read).
REQ-007 Port: cpu_addr  in  ADDR_W  CPU address.
REQ-008 Port: cpu_wdata  in  DATA_W  CPU write data.
REQ-009 Port: cpu_rdata  out  DATA_W  CPU read data; valid while cpu_ack=1.
REQ-010 Port: cpu_ack  out  1  one-cycle completion pulse to the CPU.
REQ-011 Port: ext_req, ext_we, ext_addr, ext_wdata, ext_rdata, ext_ack  (same directions and widths as the cpu_* ports)  external driver/loader port.
REQ-012 Port: ext_excl  in  1  loader-exclusive mode; while high, CPU requests are never granted.
REQ-013 Port: mem_en, mem_we  out  1  memory strobe and write enable.
REQ-014 Port: mem_addr  out  ADDR_W and mem_wdata  out  DATA_W  memory command.
REQ-015 Port: mem_rdata  in  DATA_W  memory read data, valid exactly 1 cycle after mem_en with mem_we=0.
REQ-016 Port: owner  out  2  current grant holder: 00 none, 01 CPU, 10 EXT.

Function
REQ-017 FSM states IDLE, ISSUE, RESP; reset state IDLE.
REQ-018 IDLE: if any eligible request, capture winner's we/addr/wdata into command registers, set owner, go ISSUE; else stay IDLE with owner=00.
REQ-019 ISSUE: mem_en=1 for exactly this cycle with registered command; go RESP unconditionally.
REQ-020 RESP: assert the owner's ack for exactly one cycle; owner's rdata = mem_rdata for reads; go IDLE, owner -> 00.
REQ-021 Latency: request sampled in IDLE at cycle N -> mem_en at N+1 -> ack at N+2; max one access per 3 cycles.
REQ-022 Eligibility: ext_req always eligible; cpu_req eligible only when ext_excl=0 in the sampling cycle.
REQ-023 Arbitration: round-robin with a last_grant flag; when both are eligible, grant the one not granted last; last_grant updates on every grant.
REQ-024 last_grant resets to EXT, so the CPU wins the first tie after reset.
REQ-025 Writes ack in RESP like reads; the requester's rdata is not updated on a write ack.
REQ-026 cpu_rdata and ext_rdata are registered and hold their last read value until the next read ack to that port.
REQ-027 A requester dropping req during ISSUE/RESP does not abort: access completes and ack still pulses.
REQ-028 ext_excl rising during ISSUE/RESP of a CPU access does not abort it.
REQ-029 A requester keeping req high after ack is treated as a new request in the following IDLE cycle.
REQ-030 Outside ISSUE: mem_en=0 and mem_we=0; mem_addr and mem_wdata hold the registered command.
REQ-031 Addresses and data pass unmodified; no alignment or range checking.
REQ-032 Acks are one-hot: never both high in the same cycle.

Reset
REQ-033 While reset=1 on a clock edge: state->IDLE, owner=00, last_grant=EXT, both acks=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rdata=0, ext_rdata=0.
REQ-034 Reset asserted mid-transaction aborts it: no ack is issued and mem_en is low from the next cycle.
REQ-035 First grant can occur in the first cycle after reset deasserts.

Verification
REQ-036 Single read: cpu_req=1, cpu_we=0, addr=0x10; memory returns 0xDEADBEEF -> mem_en at N+1 with addr 0x10, cpu_ack and cpu_rdata=0xDEADBEEF at N+2, owner 01 then 00.
REQ-037 Tie after reset: cpu_req and ext_req both held high -> grant order CPU, EXT, CPU, EXT; acks 3 cycles apart, never overlapping.
REQ-038 Exclusive load: ext_excl=1, both requesting, ext writes 0x11..0x14 to addrs 0..3 -> four EXT acks, zero CPU acks; drop ext_excl -> CPU granted next IDLE.
REQ-039 Write/rdata hold: EXT reads 0x55, then EXT writes 0xAA -> ext_rdata stays 0x55 after the write ack; mem_we=1 only in ISSUE.
REQ-040 Reset mid-op: assert reset in ISSUE cycle of a CPU read -> no cpu_ack, all outputs at reset values the next cycle, CPU wins the first post-reset tie.
